// File: rtl/ibex_rf_write_ctrl.sv
// ibex_rf_write_ctrl
// Write-port owner for the FPGA register file. After reset it sweeps zeros
// into x1..NUM_WORDS-1, because RAM-based storage has no reset. It then
// merges LSU and execute-stage writebacks into one registered write per
// cycle. The registered write stage is exported so the decoder can forward
// a value that has not yet landed in the RAM.
//
// Handshake: a request transfers on a rising edge where valid && ready.
// The requester holds valid, address and data stable until that edge.
// Readies depend only on the FSM state and lsu_valid_i, and never on
// ex_valid_i. The LSU has fixed priority, since load responses cannot stall.
module ibex_rf_write_ctrl #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 init_done_o,
    output logic                 illegal_waddr_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    // The counter is one bit wider than an address so that it can hold
    // NUM_WORDS. That value marks the idle cycle that ends the sweep.
    localparam logic [5:0]  DoneCnt  = 6'(NumWords);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [5:0]           clr_cnt_q, clr_cnt_d;
    logic [4:0]           rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
    logic                 rf_we_q, rf_we_d;
    logic                 init_done_q, init_done_d;
    logic                 illegal_q, illegal_d;

    logic                 lsu_acc, ex_acc;
    logic [4:0]           acc_addr;
    logic [DataWidth-1:0] acc_data;
    logic                 addr_legal;

    // Arbitration: LSU always accepted in RUN; EX only when the LSU is idle.
    always_comb begin
        lsu_ready_o = (state_q == RUN);
        ex_ready_o  = (state_q == RUN) && !lsu_valid_i;
        lsu_acc     = lsu_valid_i && lsu_ready_o;
        ex_acc      = ex_valid_i && ex_ready_o;
        acc_addr    = lsu_acc ? lsu_waddr_i : ex_waddr_i;
        acc_data    = lsu_acc ? lsu_wdata_i : ex_wdata_i;
        // With RV32E, x16..x31 do not exist. Such writes are accepted and dropped.
        addr_legal  = !(RV32E && acc_addr[4]);
    end

    // Next state: clear sweep in INIT, then one registered write per accept.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_we_d     = 1'b0;
        init_done_d = init_done_q;
        illegal_d   = 1'b0;
        unique case (state_q)
            INIT: begin
                if (clr_cnt_q == DoneCnt) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    rf_waddr_d = clr_cnt_q[4:0];
                    rf_wdata_d = '0;
                    rf_we_d    = 1'b1;
                    clr_cnt_d  = clr_cnt_q + 6'd1;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (lsu_acc || ex_acc) begin
                    rf_waddr_d = acc_addr;
                    rf_wdata_d = acc_data;
                    rf_we_d    = (acc_addr != 5'd0) && addr_legal;
                    illegal_d  = !addr_legal;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and write-stage registers; a reset discards any in-flight write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            clr_cnt_q   <= 6'd1;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            init_done_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            init_done_q <= init_done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign rf_we_o         = rf_we_q;
    assign init_done_o     = init_done_q;
    assign illegal_waddr_o = illegal_q;

endmodule

// File: tb/tb_ibex_rf_write_ctrl.sv
// Bench for ibex_rf_write_ctrl. Two instances (RV32I and RV32E) share the
// request inputs. Only the selected instance is out of reset at any time.
module tb_ibex_rf_write_ctrl;

  localparam int W = 40;  // {we, illegal, init_done, waddr[4:0], wdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cur_e;
  logic        rst_ni_i, rst_ni_e;
  assign rst_ni_i = cur_e ? 1'b0 : rst_n;
  assign rst_ni_e = cur_e ? rst_n : 1'b0;

  logic        ex_valid, lsu_valid;
  logic [4:0]  ex_waddr, lsu_waddr;
  logic [31:0] ex_wdata, lsu_wdata;

  logic        ex_ready_i, lsu_ready_i, we_i, done_i, ill_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        ex_ready_e, lsu_ready_e, we_e, done_e, ill_e;
  logic [4:0]  waddr_e;
  logic [31:0] wdata_e;

  ibex_rf_write_ctrl #(.RV32E(1'b0), .DataWidth(32)) dut_i (
    .clk_i(clk), .rst_ni(rst_ni_i),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready_i),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready_i),
    .rf_waddr_o(waddr_i), .rf_wdata_o(wdata_i), .rf_we_o(we_i),
    .init_done_o(done_i), .illegal_waddr_o(ill_i)
  );

  ibex_rf_write_ctrl #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_ni(rst_ni_e),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready_e),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready_e),
    .rf_waddr_o(waddr_e), .rf_wdata_o(wdata_e), .rf_we_o(we_e),
    .init_done_o(done_e), .illegal_waddr_o(ill_e)
  );

  logic [W-1:0] mon_vec;
  logic         mon_ex_ready, mon_lsu_ready;
  assign mon_vec = cur_e ? {we_e, ill_e, done_e, waddr_e, wdata_e}
                         : {we_i, ill_i, done_i, waddr_i, wdata_i};
  assign mon_ex_ready  = cur_e ? ex_ready_e : ex_ready_i;
  assign mon_lsu_ready = cur_e ? lsu_ready_e : lsu_ready_i;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Every edge that has an expectation queued is compared #1 after the edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (mon_vec !== e) begin
          n_errors++;
          $display("FAIL wr_stage t=%0t: got we=%b ill=%b done=%b addr=%0d data=%h exp we=%b ill=%b done=%b addr=%0d data=%h",
                   $time, mon_vec[39], mon_vec[38], mon_vec[37], mon_vec[36:32], mon_vec[31:0],
                   e[39], e[38], e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // The sweep writes 1..N-1, is followed by one idle cycle that raises
  // init_done, and after that every accepted request appears on the next edge.
  bit          in_run;
  int          sweep_k;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  bit          ex_pend;
  logic [4:0]  ex_a;
  logic [31:0] ex_d;

  function automatic int num_words();
    return cur_e ? 16 : 32;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %b exp %b", name, $time, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: present the inputs, check the readies, queue the expected write stage.
  task automatic drive(input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit new_ex, input logic [4:0] ea, input logic [31:0] ed);
    bit          acc_ex, acc_any, legal;
    logic [4:0]  a;
    logic [31:0] d;
    if (new_ex && !ex_pend) begin
      ex_pend = 1'b1; ex_a = ea; ex_d = ed;
    end
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    ex_valid  = ex_pend; ex_waddr = ex_a; ex_wdata = ex_d;
    #1;
    check_bit("lsu_ready", mon_lsu_ready, in_run);
    check_bit("ex_ready", mon_ex_ready, in_run && !lv);
    acc_ex = 1'b0;
    if (!in_run) begin
      if (sweep_k <= num_words() - 1) begin
        last_a = 5'(sweep_k); last_d = '0;
        exp_q.push_back({1'b1, 1'b0, 1'b0, last_a, last_d});
        sweep_k++;
      end else begin
        exp_q.push_back({1'b0, 1'b0, 1'b1, last_a, last_d});
        in_run = 1'b1;
      end
    end else begin
      acc_any = lv || ex_pend;
      acc_ex  = !lv && ex_pend;
      a = lv ? la : ex_a;
      d = lv ? ld : ex_d;
      if (acc_any) begin
        legal  = !(cur_e && (a >= 5'd16));
        last_a = a; last_d = d;
        exp_q.push_back({(a != 5'd0) && legal, !legal, 1'b1, a, d});
      end else begin
        exp_q.push_back({1'b0, 1'b0, 1'b1, last_a, last_d});
      end
    end
    @(posedge clk);
    if (acc_ex) ex_pend = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    ex_pend = 1'b0;
    ex_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back('0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_run = 1'b0; sweep_k = 1; last_a = '0; last_d = '0;
  endtask

  task automatic finish_sweep();
    for (int i = 0; i < 40 && !in_run; i++) idle();
    check_bit("sweep_ends", in_run, 1'b1);
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++)
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; cur_e = 1'b0;
    ex_valid = 1'b0; lsu_valid = 1'b0;
    ex_waddr = '0; lsu_waddr = '0; ex_wdata = '0; lsu_wdata = '0;
    ex_pend = 1'b0; ex_a = '0; ex_d = '0;
    in_run = 1'b0; sweep_k = 1; last_a = '0; last_d = '0;
    @(negedge clk);

    // RV32I: full sweep with requests offered (they must be ignored in INIT).
    do_reset(2);
    for (int i = 0; i < 40 && !in_run; i++)
      drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    check_bit("sweep_ends", in_run, 1'b1);

    // Priority: the LSU wins, and the held EX request lands on the next cycle.
    drive(1'b1, 5'd6, 32'h1234_5678, 1'b1, 5'd5, 32'hAAAA_0000);
    idle();
    // Back-to-back EX writes.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0011);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0022);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033);
    // A write to x0 is accepted without a write enable.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    idle();
    random_traffic(300);

    // Reset while running, then reset in the middle of the sweep at x10.
    do_reset(1);
    drive(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd7, 32'h7777_7777);
    for (int i = 0; i < 9; i++) idle();
    do_reset(2);
    finish_sweep();
    random_traffic(100);

    // RV32E instance: 15-entry sweep and illegal-address handling.
    cur_e = 1'b1;
    do_reset(2);
    finish_sweep();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'h1717_1717);
    idle();
    drive(1'b1, 5'd31, 32'h3131_3131, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 5'd15, 32'h1515_1515, 1'b0, 5'd0, 32'd0);
    random_traffic(300);

    ex_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ibex_rf_write_ctrl.md
# ibex_rf_write_ctrl

Write-side controller for the FPGA register file; it is the only driver of the file's single write port. After reset it clears registers 1..NUM_WORDS-1, because RAM-inferred storage has no reset. It then arbitrates writeback requests from the execute stage and the LSU into one registered write per cycle. The registered write-stage contents are also exported so the decoder can forward a write that has not yet landed in the RAM.

## Interface
Parameters:
- RV32E, 0: 1 selects 16 registers (4-bit effective address); 0 selects 32.
- DataWidth, 32: width of the register data.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- ex_valid_i  in  1  execute-stage writeback request.
- ex_waddr_i  in  5  execute-stage destination register.
- ex_wdata_i  in  DataWidth  execute-stage write data.
- ex_ready_o  out  1  execute request accepted this cycle.
- lsu_valid_i  in  1  load writeback request.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  DataWidth  load write data.
- lsu_ready_o  out  1  load request accepted this cycle.
- rf_waddr_o  out  5  register file write address.
- rf_wdata_o  out  DataWidth  register file write data.
- rf_we_o  out  1  register file write enable.
- init_done_o  out  1  clearing finished; normal operation.
- illegal_waddr_o  out  1  one-cycle pulse: an accepted write targeted x16..x31 with RV32E=1.

## Operation
- NUM_WORDS = RV32E ? 16 : 32.
- FSM states:
  - INIT: entered on reset.
  - RUN: entered after the clear sweep.
- INIT behaviour:
  - A counter clr_cnt starts at 1.
  - Each cycle the write stage loads addr=clr_cnt, data=0, we=1, then clr_cnt increments.
  - When addr NUM_WORDS-1 has been loaded, the next edge moves the FSM to RUN.
  - x0 is never written.
  - ex_ready_o=0 and lsu_ready_o=0 throughout INIT.
- RUN arbitration:
  - LSU has fixed priority. lsu_ready_o=1 in every RUN cycle, because load responses cannot stall.
  - ex_ready_o = !lsu_valid_i.
  - Both readies depend combinationally on state and lsu_valid_i only, never on ex_valid_i.
- Accepted request (valid && ready):
  - On the next edge, rf_waddr_o and rf_wdata_o load the request's address and data.
  - rf_we_o loads 1 only if the address is non-zero and the address is legal (bit 4 clear when RV32E=1).
- Write to x0: accepted; rf_we_o=0 and no error.
- Illegal RV32E address: accepted and dropped. rf_we_o=0; illegal_waddr_o=1 for exactly the following cycle.
- No accepted request: rf_we_o loads 0. rf_waddr_o and rf_wdata_o hold their previous values.
- Forwarding contract: a write presented on rf_*_o lands in the RAM at the end of that cycle. While rf_we_o=1, the decoder bypasses any read of rf_waddr_o with rf_wdata_o.
- Reset mid-operation (rst_ni=0 at an edge, in any state):
  - FSM goes to INIT, clr_cnt goes to 1, and the registered outputs are cleared.
  - Any in-flight write stage is discarded.
  - Clearing restarts from x1.

## Timing
- Reset values (after any edge with rst_ni=0): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, init_done_o=0, illegal_waddr_o=0.
- Let E1 be the first edge with rst_ni=1:
  - rf_we_o=1 and rf_waddr_o=1 after E1.
  - rf_waddr_o=k after edge Ek, for k = 1..NUM_WORDS-1.
  - After edge E(NUM_WORDS): init_done_o=1 (registered) and rf_we_o=0.
  - Readies can assert in that same cycle.
- Clear sweep length: NUM_WORDS-1 cycles (31 for RV32I, 15 for RV32E).
- Accept-to-write latency: exactly 1 cycle. Throughput: 1 write per cycle, with no bubbles between back-to-back accepts.
- Simultaneous ex_valid_i and lsu_valid_i: the LSU is written; the EX request sees ex_ready_o=0 and must hold valid, address and data until accepted.
- rf_waddr_o always carries the full 5 bits. The register file is responsible for truncation.

## Test plan
- Clear sweep, RV32I: release reset -> rf_we_o=1 with rf_waddr_o stepping 1..31 and rf_wdata_o=0 on 31 consecutive cycles. init_done_o rises on the 32nd edge. No write to x0.
- Priority: in RUN, same cycle ex (x5, 0xAAAA_0000) and lsu (x6, 0x1234_5678) -> next cycle writes x6=0x1234_5678 with ex_ready_o=0. The held EX request is written as x5 on the following cycle.
- Back-to-back EX: EX writes to x1, x2, x3 on consecutive cycles with no LSU traffic -> three consecutive rf_we_o=1 cycles with matching address and data.
- x0 write: EX write to x0 with data 0xFFFF_FFFF -> ex_ready_o=1; next cycle rf_we_o=0 and illegal_waddr_o=0.
- RV32E: clear sweep covers x1..x15 only (init_done_o on the 16th edge). A write to x17 -> rf_we_o=0 and a one-cycle illegal_waddr_o pulse.
- Reset mid-sweep: assert rst_ni=0 at sweep address 10, release it -> outputs zero during reset, then the sweep restarts at x1. Mid-RUN reset drops init_done_o and both readies.
